// File: rtl/seq_link_pkg.sv
// Shared definitions for the 0101 serial link: state encodings, sync pattern,
// idle line level and a counter-width helper used by transmitter and detector.
package seq_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRE   = 2'b01,
    DATA  = 2'b10,
    GUARD = 2'b11
  } tx_state_e;

  // Detector state encodings, kept alongside the transmitter's for shared debug decode
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  localparam logic [3:0] SYNC_PATTERN = 4'b0101;
  localparam logic       DEF_IDLE_BIT = 1'b1;

  // Bits needed to index the longer of the two phases, never less than one
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Loadable MSB-first parallel-in/serial-out shift register with a phase bit
// counter and a flag marking the last bit of the current phase.
module seq_piso
  import seq_link_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  input  logic [CNT_W-1:0]  last_idx,
  output logic              msb,
  output logic [CNT_W-1:0]  cnt,
  output logic              last
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  // Clear wins over increment so a phase change always restarts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign msb  = sr_q[DATA_W-1];
  assign last = (cnt == last_idx);

endmodule

// File: rtl/seq_0101_tx.sv
// Serial frame transmitter: preamble, MSB-first data word, one guard bit at
// idle level; accepts words over a valid/ready handshake, back-to-back capable.
module seq_0101_tx
  import seq_link_pkg::*;
#(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(SYNC_PATTERN),
  parameter logic             IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              serial_out,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        pst
);

  localparam int unsigned      CNT_W     = cnt_width(PRE_W, DATA_W);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  tx_state_e        state_q, state_d;
  logic             so_d, ov_d, fd_d, busy_d;
  logic             accept_c;
  logic             piso_load, piso_shift, cnt_clr, cnt_inc;
  logic [CNT_W-1:0] last_idx;
  logic             msb, last;
  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre_tail;
  logic             pre_next;

  seq_piso #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (piso_load),
    .din     (data_in),
    .shift   (piso_shift),
    .cnt_clr (cnt_clr),
    .cnt_inc (cnt_inc),
    .last_idx(last_idx),
    .msb     (msb),
    .cnt     (cnt),
    .last    (last)
  );

  // Ready depends only on the state register, never on load_valid
  assign load_ready = ~rst & ((state_q == IDLE) | (state_q == GUARD));
  assign accept_c   = load_valid & load_ready;
  assign pst        = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      serial_out <= IDLE_BIT;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      serial_out <= so_d;
      out_valid  <= ov_d;
      busy       <= busy_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    so_d       = serial_out;
    ov_d       = out_valid;
    fd_d       = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    last_idx   = (state_q == PRE) ? PRE_LAST : DATA_LAST;
    // Preamble bit that follows the one currently on the line
    pre_tail   = (PREAMBLE << cnt) << 1;
    pre_next   = pre_tail[PRE_W-1];

    unique case (state_q)
      IDLE, GUARD: begin
        state_d = IDLE;
        so_d    = IDLE_BIT;
        ov_d    = 1'b0;
        if (accept_c) begin
          state_d   = PRE;
          piso_load = 1'b1;
          cnt_clr   = 1'b1;
          so_d      = PREAMBLE[PRE_W-1];
          ov_d      = 1'b1;
        end
      end
      PRE: begin
        ov_d = 1'b1;
        if (last) begin
          state_d    = DATA;
          so_d       = msb;
          piso_shift = 1'b1;
          cnt_clr    = 1'b1;
        end else begin
          so_d    = pre_next;
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (last) begin
          state_d = GUARD;
          so_d    = IDLE_BIT;
          ov_d    = 1'b0;
          fd_d    = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          so_d       = msb;
          ov_d       = 1'b1;
          piso_shift = 1'b1;
          cnt_inc    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
